// File: rtl/cache_pkg.sv
// Shared geometry and FSM state type for the L1 miss/fill path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cache_pkg;

    localparam int WORDS_PER_BLOCK   = 8;
    localparam int WORD_IDX_BITS     = 3;
    localparam int BLOCK_OFFSET_BITS = WORD_IDX_BITS + 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } fill_state_t;

endpackage

// File: rtl/fill_counter.sv
// Saturating up-counter with enable, synchronous clear and terminal-count flag.
// Latency: count updates one cycle after en; tc is a decode of the current count.
// Backpressure: none; holds at MAX while en stays high.
module fill_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] cnt,
    output logic             tc
);

    assign tc = (cnt == WIDTH'(MAX));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && !tc) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cache_fill_fsm.sv
// L1 miss handler: latches the block base, issues one word read per cycle, steers returns into the data array.
// Latency: first read issued the cycle after miss_detected; busy for WORDS_PER_BLOCK + memory latency cycles.
// Backpressure: stalls the pipeline via fsm_busy; memory returns are never throttled.
module cache_fill_fsm
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     miss_detected,
    input  logic [ADDR_WIDTH-1:0]    miss_address,
    input  logic                     mem_data_valid,
    input  logic [15:0]              mem_data,
    output logic                     fsm_busy,
    output logic [ADDR_WIDTH-1:0]    memory_address,
    output logic                     mem_en,
    output logic                     write_data_array,
    output logic                     write_tag_array,
    output logic [WORD_IDX_BITS-1:0] data_word_sel,
    output logic [15:0]              fill_data
);

    localparam int ISSUE_W = WORD_IDX_BITS + 1;

    fill_state_t             state;
    fill_state_t             state_nxt;
    logic [ADDR_WIDTH-1:0]   base_addr;
    logic [ISSUE_W-1:0]      issue_cnt;
    logic [WORD_IDX_BITS-1:0] recv_cnt;
    logic                    issue_done;
    logic                    recv_last;
    logic                    in_fill;
    logic                    issue_en;
    logic                    recv_en;
    logic                    fill_done;

    assign in_fill   = (state == ST_FILL);
    assign issue_en  = in_fill && !issue_done;
    assign recv_en   = in_fill && mem_data_valid;
    assign fill_done = recv_en && recv_last;

    // Issue counter runs one past the last word so its tc flags "all reads issued".
    fill_counter #(.WIDTH(ISSUE_W), .MAX(WORDS_PER_BLOCK)) u_issue_cnt (
        .clk (clk),
        .rst (rst),
        .clr (fill_done),
        .en  (issue_en),
        .cnt (issue_cnt),
        .tc  (issue_done)
    );

    fill_counter #(.WIDTH(WORD_IDX_BITS), .MAX(WORDS_PER_BLOCK - 1)) u_recv_cnt (
        .clk (clk),
        .rst (rst),
        .clr (fill_done),
        .en  (recv_en),
        .cnt (recv_cnt),
        .tc  (recv_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            base_addr <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && miss_detected) begin
                base_addr <= {miss_address[ADDR_WIDTH-1:BLOCK_OFFSET_BITS], BLOCK_OFFSET_BITS'(0)};
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (miss_detected) state_nxt = ST_FILL;
            ST_FILL: if (fill_done)     state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Base is block-aligned, so the word offset add never carries past the block.
    assign memory_address   = in_fill ? (base_addr + (ADDR_WIDTH'(issue_cnt) << 1)) : '0;
    assign mem_en           = issue_en;
    assign fsm_busy         = in_fill;
    assign write_data_array = recv_en;
    assign write_tag_array  = fill_done;
    assign data_word_sel    = recv_cnt;
    assign fill_data        = mem_data;

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Miss handler between the L1 cache arrays and the pipelined main memory model.
- On a cache miss it latches the block base address and issues one word read per cycle for all 8 words of the block.
- It counts returned words, steers each into the data array at the correct word offset, and writes the tag array when the last word lands.
- Stalls the pipeline via fsm_busy for the whole fill.

Parameters:
- ADDR_WIDTH, 16, byte-address width.
- WORDS_PER_BLOCK, 8, 16-bit words per cache block; must be a power of two.
- WORD_IDX_BITS, 3, log2(WORDS_PER_BLOCK).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- miss_detected  in  1  cache lookup missed this cycle; sampled only in IDLE.
- miss_address  in  ADDR_WIDTH  byte address of the missing access.
- mem_data_valid  in  1  memory returns one word this cycle; words return in issue order.
- mem_data  in  16  returned word; valid only with mem_data_valid.
- fsm_busy  out  1  fill in progress; the pipeline stalls while high.
- memory_address  out  ADDR_WIDTH  word-aligned read address to memory (bit 0 always 0).
- mem_en  out  1  read request to memory this cycle (write enable to memory is tied 0 by the parent).
- write_data_array  out  1  write fill_data into the data array at data_word_sel.
- write_tag_array  out  1  write tag/valid for the block being filled.
- data_word_sel  out  WORD_IDX_BITS  word offset within the block for the current data write.
- fill_data  out  16  equals mem_data (combinational pass-through).

Behaviour:
- States:
  - IDLE: default state; a miss_detected moves to FILL.
  - FILL: issues reads and collects returned words.
- Reset:
  - State goes to IDLE; issue_cnt, recv_cnt and base_addr are cleared.
  - All outputs are 0 except fill_data, which tracks mem_data.
- IDLE:
  - On a cycle with miss_detected=1: base_addr <= miss_address with the low (WORD_IDX_BITS+1) bits cleared; move to FILL.
  - No memory request is issued in the detect cycle.
- fsm_busy = (state==FILL), a registered-state decode.
- Issue side, in FILL:
  - mem_en = (issue_cnt < WORDS_PER_BLOCK).
  - memory_address = base_addr + (issue_cnt << 1).
  - issue_cnt increments each cycle mem_en=1 and saturates at WORDS_PER_BLOCK.
  - In IDLE, mem_en=0 and memory_address=0.
- Receive side, in FILL:
  - write_data_array = mem_data_valid.
  - data_word_sel = recv_cnt.
  - recv_cnt increments on each mem_data_valid.
- Completion:
  - Occurs on the cycle with mem_data_valid=1 and recv_cnt==WORDS_PER_BLOCK-1.
  - write_tag_array=1 in that same cycle (combinational, alongside the last data write).
  - Next state is IDLE; both counters clear.
- Latency: with memory return latency L cycles after issue, fsm_busy stays high for WORDS_PER_BLOCK + L cycles. With L=0, 8 cycles.
- Boundary conditions:
  - miss_detected while in FILL: ignored; miss_address is not re-latched.
  - mem_data_valid in IDLE: ignored; no array writes.
  - Valid returns that overlap issuing: legal, handled by the independent counters.
  - Return before the matching issue: illegal; covered by an assertion in the bench.
  - Reset mid-fill: returns to IDLE next edge; no tag write; a partially written data block is left as-is (its tag is never validated).
  - Address wrap: base_addr + 14 never carries out of the block because base is block-aligned.
  - Back-to-back misses: a miss asserted in the cycle right after completion (state IDLE) is accepted.

Decomposition:
- Shared package (cache_pkg): WORDS_PER_BLOCK, WORD_IDX_BITS, BLOCK_OFFSET_BITS, and the state enum (ST_IDLE, ST_FILL).
- One natural sub-module, fill_counter: a saturating up-counter with enable, clear and terminal-count flag.
  - Instantiated twice, for issue and receive.
- Top-level holds the FSM, base_addr register and output decode.

Test Plan:
- Zero-latency fill:
  - Stimulus: reset; miss at 0x1236; memory returns 0xA000+i the same cycle as each issue.
  - Response: addresses 0x1230..0x123E in 8 consecutive cycles; data_word_sel 0..7; write_tag_array only on the 8th; fsm_busy high exactly 8 cycles.
- 4-cycle latency fill:
  - Stimulus: miss at 0x00F0; mem_data_valid 4 cycles after each issue.
  - Response: mem_en high 8 cycles then low; fsm_busy high 12 cycles; tag write in the cycle word 7 returns.
- Ignored miss during fill:
  - Stimulus: a second miss at 0x8000 during the fill of 0x0040.
  - Response: all addresses stay within 0x0040..0x004E; no refill starts.
- Reset mid-fill:
  - Stimulus: assert rst after 3 words returned.
  - Response: next cycle state IDLE, fsm_busy=0, no write_tag_array; a new miss at 0x0200 restarts at word 0.
- Back-to-back misses and stray data:
  - Stimulus: second miss asserted the cycle after completion; mem_data_valid pulsed while IDLE.
  - Response: the second fill starts immediately; no write_data_array during the stray IDLE pulse.
